// File: rtl/dl_pkg.sv
// Shared types for the dl skid buffer: FSM state encoding and occupancy helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dl_pkg;

   // Buffer fill state; encoding doubles as the entry count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } dl_state_t;

   localparam int unsigned DL_DEPTH = 2;

   // Entries held for a given state.
   function automatic logic [1:0] dl_occ_of(input dl_state_t s);
      case (s)
         ST_BUSY: dl_occ_of = 2'd1;
         ST_FULL: dl_occ_of = 2'd2;
         default: dl_occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/dl_dff_en.sv
// WIDTH-bit data flop with load enable and no reset.
// Latency: 1 cycle from i_en to o_q.
// Backpressure: none; holds value whenever i_en is low.
module dl_dff_en #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Capture i_d only when loaded, so idle cycles never toggle the register.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry register slice (main + skid) with fully registered outputs.
// Latency: 1 cycle in_fire -> out_valid when empty; 1 transfer/cycle sustained.
// Backpressure: in_ready drops only when both entries are held; skid absorbs one beat.
module dl_skid_buf
   import dl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   dl_state_t        r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [1:0]       r_occupancy;

   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_main_en;
   logic             w_skid_en;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   // Handshakes use only the registered ready/valid, so fires are legal by construction.
   assign w_in_fire  = in_valid  & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   // Main loads from input except when draining the skid entry forward.
   assign w_main_d  = (r_state == ST_FULL) ? w_skid_q : in_data;
   assign w_main_en = !rst &&
                      (((r_state == ST_EMPTY) && w_in_fire) ||
                       ((r_state == ST_BUSY)  && w_in_fire && w_out_fire) ||
                       ((r_state == ST_FULL)  && w_out_fire));
   assign w_skid_en = !rst && (r_state == ST_BUSY) && w_in_fire && !w_out_fire;

   dl_dff_en #(.WIDTH(WIDTH)) u_main (
      .i_clk (clk),
      .i_en  (w_main_en),
      .i_d   (w_main_d),
      .o_q   (w_main_q)
   );

   dl_dff_en #(.WIDTH(WIDTH)) u_skid (
      .i_clk (clk),
      .i_en  (w_skid_en),
      .i_d   (in_data),
      .o_q   (w_skid_q)
   );

   // Fill-state FSM; outputs are updated alongside the state so none depend on inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_occupancy <= dl_occ_of(ST_EMPTY);
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  r_state     <= ST_BUSY;
                  r_out_valid <= 1'b1;
                  r_occupancy <= dl_occ_of(ST_BUSY);
               end
            end
            ST_BUSY: begin
               if (w_in_fire && !w_out_fire) begin
                  r_state     <= ST_FULL;
                  r_in_ready  <= 1'b0;
                  r_occupancy <= dl_occ_of(ST_FULL);
               end else if (!w_in_fire && w_out_fire) begin
                  r_state     <= ST_EMPTY;
                  r_out_valid <= 1'b0;
                  r_occupancy <= dl_occ_of(ST_EMPTY);
               end
            end
            ST_FULL: begin
               if (w_out_fire) begin
                  r_state     <= ST_BUSY;
                  r_in_ready  <= 1'b1;
                  r_occupancy <= dl_occ_of(ST_BUSY);
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_occupancy <= dl_occ_of(ST_EMPTY);
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = w_main_q;
   assign occupancy = r_occupancy;

endmodule

// File: tb/tb_dl_skid_buf.sv
// Self-checking bench for dl_skid_buf: directed vectors plus a randomised queue-model run.
// Latency: n/a.
// Backpressure: exercised via out_ready patterns.
module tb_dl_skid_buf;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       occupancy;

   int n_chk;
   int n_err;

   dl_skid_buf #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic r,
                            input logic [1:0] o);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".in_ready"},  64'(in_ready),  64'(r));
      chk({tag, ".occupancy"}, 64'(occupancy), 64'(o));
   endtask

   logic [WIDTH-1:0] q[$];

   initial begin
      n_chk     = 0;
      n_err     = 0;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h99;
      out_ready = 1'b0;

      // Reset held 2 cycles with input offered.
      step();
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk_state("rst", 1'b0, 1'b1, 2'd0);
      step();
      chk_state("rst_idle", 1'b0, 1'b1, 2'd0);

      // Streaming with out_ready high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h1;
      step();
      chk_state("strm1", 1'b1, 1'b1, 2'd1);
      chk("strm1.data", 64'(out_data), 64'h1);
      in_data = 32'h2;
      step();
      chk_state("strm2", 1'b1, 1'b1, 2'd1);
      chk("strm2.data", 64'(out_data), 64'h2);
      in_data = 32'h3;
      step();
      chk_state("strm3", 1'b1, 1'b1, 2'd1);
      chk("strm3.data", 64'(out_data), 64'h3);
      in_valid = 1'b0;
      step();
      chk_state("strm_drain", 1'b0, 1'b1, 2'd0);

      // Backpressure: A, B accepted, C held off.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA;
      step();
      chk_state("bp_a", 1'b1, 1'b1, 2'd1);
      chk("bp_a.data", 64'(out_data), 64'hA);
      in_data = 32'hB;
      step();
      chk_state("bp_b", 1'b1, 1'b0, 2'd2);
      chk("bp_b.data", 64'(out_data), 64'hA);
      in_data = 32'hC;
      step();
      chk_state("bp_c_held", 1'b1, 1'b0, 2'd2);
      chk("bp_c_held.data", 64'(out_data), 64'hA);
      out_ready = 1'b1;
      step();
      chk_state("bp_pop_a", 1'b1, 1'b1, 2'd1);
      chk("bp_pop_a.data", 64'(out_data), 64'hB);
      step();
      chk_state("bp_pop_b", 1'b1, 1'b1, 2'd1);
      chk("bp_pop_b.data", 64'(out_data), 64'hC);
      in_valid = 1'b0;
      step();
      chk_state("bp_pop_c", 1'b0, 1'b1, 2'd0);

      // Simultaneous push/pop while BUSY.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h5;
      step();
      chk("sim_5.data", 64'(out_data), 64'h5);
      in_data   = 32'h6;
      out_ready = 1'b1;
      step();
      chk_state("sim_6", 1'b1, 1'b1, 2'd1);
      chk("sim_6.data", 64'(out_data), 64'h6);
      in_valid = 1'b0;
      step();
      chk_state("sim_drain", 1'b0, 1'b1, 2'd0);

      // Reset while FULL, with concurrent fires offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h7;
      step();
      in_data = 32'h8;
      step();
      chk_state("full78", 1'b1, 1'b0, 2'd2);
      chk("full78.data", 64'(out_data), 64'h7);
      rst       = 1'b1;
      out_ready = 1'b1;
      in_data   = 32'h9;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk_state("midrst", 1'b0, 1'b1, 2'd0);
      step();
      chk_state("midrst_after", 1'b0, 1'b1, 2'd0);

      // Random traffic against a queue model; also checks outputs ignore same-cycle inputs.
      q.delete();
      for (int i = 0; i < 10000; i++) begin
         logic             e_in_fire;
         logic             e_out_fire;
         logic             s_v;
         logic             s_r;
         logic [1:0]       s_o;
         logic [WIDTH-1:0] s_d;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         e_in_fire  = in_valid && (q.size() < 2);
         e_out_fire = out_ready && (q.size() > 0);
         step();
         if (e_out_fire) void'(q.pop_front());
         if (e_in_fire)  q.push_back(in_data);
         chk_state("rnd", 1'(q.size() > 0), 1'(q.size() < 2), 2'(q.size()));
         if (q.size() > 0) chk("rnd.data", 64'(out_data), 64'(q[0]));
         s_v = out_valid;
         s_r = in_ready;
         s_o = occupancy;
         s_d = out_data;
         in_valid  = ~in_valid;
         out_ready = ~out_ready;
         in_data   = ~in_data;
         #1;
         if ((i % 16) == 0) begin
            chk("comb.out_valid", 64'(out_valid), 64'(s_v));
            chk("comb.in_ready",  64'(in_ready),  64'(s_r));
            chk("comb.occupancy", 64'(occupancy), 64'(s_o));
            chk("comb.out_data",  64'(out_data),  64'(s_d));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/dl_skid_buf.md
DL_SKID_BUF -- requirements
Module: dl_skid_buf

Interface
REQ-001 The block SHALL have parameter: WIDTH, 32, payload width in bits (legal range 1..256).
REQ-002 The block SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: in_valid  input  1  upstream offers in_data this cycle.
REQ-005 The block SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-006 The block SHALL have port: in_data  input  WIDTH  upstream payload.
REQ-007 The block SHALL have port: out_valid  output  1  out_data holds a valid entry.
REQ-008 The block SHALL have port: out_ready  input  1  downstream consumes out_data this cycle.
REQ-009 The block SHALL have port: out_data  output  WIDTH  oldest held payload.
REQ-010 The block SHALL have port: occupancy  output  2  entries held (0..2).

Function
REQ-011 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; a transfer SHALL occur only on a fire.
REQ-012 The block SHALL be a 2-entry register slice: main register (head) plus skid register (overflow).
REQ-013 State machine SHALL have states EMPTY (0 entries), BUSY (main only), FULL (main+skid).
REQ-014 in_ready, out_valid, out_data and occupancy SHALL be driven purely from registers: no combinational path from any input to any output.
REQ-015 out_valid SHALL be 1 in BUSY/FULL, 0 in EMPTY; out_data SHALL equal main register.
REQ-016 in_ready SHALL be 1 in EMPTY/BUSY, 0 in FULL.
REQ-017 EMPTY: in_fire -> main<=in_data, go BUSY; else stay EMPTY.
REQ-018 BUSY: in_fire & out_fire -> main<=in_data, stay BUSY; in_fire only -> skid<=in_data, go FULL; out_fire only -> go EMPTY; neither -> hold.
REQ-019 FULL: out_fire -> main<=skid, go BUSY; else hold (in_fire impossible).
REQ-020 Latency SHALL be exactly 1 cycle from in_fire to out_valid when EMPTY; throughput SHALL be 1 transfer/cycle when out_ready held high.
REQ-021 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated.
REQ-022 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Data registers SHALL load only on the fires above (no toggling when idle).

Reset
REQ-025 rst=1 at a rising edge SHALL force EMPTY: out_valid=0, in_ready=1, occupancy=0, regardless of concurrent fires; pending entries are discarded.
REQ-026 Data registers SHALL NOT require reset; out_data is don't-care while out_valid=0.
REQ-027 Reset asserted mid-transfer SHALL take priority over all state transitions in that cycle.

Structure
REQ-028 State enum (EMPTY/BUSY/FULL, 2-bit encoding 0/1/2) SHALL live in shared package dl_pkg.
REQ-029 Main and skid registers SHALL each be an instance of one sub-module dl_dff_en (WIDTH-bit flop with load enable, no reset).
REQ-030 Control FSM SHALL be a single always block in dl_skid_buf.

Verification
REQ-031 Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0 after release.
REQ-032 Streaming: out_ready=1, push 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, occupancy=1 throughout.
REQ-033 Backpressure: out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0, occupancy=2, 0xC held; then out_ready=1 -> 0xA,0xB,0xC delivered in order.
REQ-034 Simultaneous: BUSY with 0x5, in_fire 0x6 and out_fire same cycle -> stays BUSY, out_data=0x6.
REQ-035 Mid-op reset: FULL with 0x7,0x8, assert rst -> next cycle EMPTY, 0x7/0x8 never appear.
REQ-036 Random: 10k cycles random in_valid/out_ready -> scoreboard FIFO match, no input-to-output combinational path.
